lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles waiting on gnt/rvalid before aborting.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in  input  1  instr/alu_result/rs2_data valid this cycle.
REQ-005 SHALL have port instr  input  instr_t  MEM-stage instruction; opcode and funct3 are used.
REQ-006 SHALL have port alu_result  input  data_t  effective byte address.
REQ-007 SHALL have port rs2_data  input  data_t  store source data.
REQ-008 SHALL have port mem_data  output  data_t  extended load result for writeback.
REQ-009 SHALL have port done  output  1  one-cycle pulse; mem_data/err valid.
REQ-010 SHALL have port stall  output  1  pipeline hold while an access is outstanding.
REQ-011 SHALL have port err  output  1  misaligned or timed-out access, valid with done.
REQ-012 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out data_t (word-aligned), bus_wdata out data_t, bus_be out 4.
REQ-013 SHALL have ports bus_gnt in 1 (request accepted), bus_rvalid in 1 (read data/write ack), bus_rdata in data_t.

Function
REQ-014 SHALL act only when valid_in=1, state IDLE, opcode LOAD or STORE; all other opcodes pass through with no bus activity and no done.
REQ-015 SHALL implement FSM IDLE -> REQ -> WAIT -> DONE -> IDLE, state type lsu_state_t.
REQ-016 IDLE: on accepted LOAD/STORE, register addr, funct3, we, wdata, be; go to REQ next cycle.
REQ-017 REQ: hold bus_req=1 and stable bus_* until bus_gnt=1; then go WAIT.
REQ-018 WAIT: bus_req=0; on bus_rvalid=1 capture bus_rdata (loads) and go DONE.
REQ-019 gnt and rvalid in the same cycle while in REQ SHALL go directly to DONE, capturing data.
REQ-020 DONE: done=1 for exactly one cycle; return to IDLE.
REQ-021 stall SHALL be 1 in REQ and WAIT, and in IDLE the cycle a LOAD/STORE is accepted; 0 in DONE.
REQ-022 Minimum latency, gnt and rvalid both immediate: accept cycle N, done cycle N+2.
REQ-023 bus_addr SHALL be {alu_result[31:2],2'b00}; byte lane = alu_result[1:0].
REQ-024 Store lanes: SB be=0001<<off, wdata=byte replicated x4; SH be=0011<<off, wdata=half replicated x2; SW be=1111, wdata=rs2_data.
REQ-025 Loads SHALL read be=1111; select lane by offset; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-026 Misaligned (LH/LHU/SH with off[0]=1; LW/SW with off!=0) SHALL issue no bus request; go straight to DONE with err=1, mem_data=NULL.
REQ-027 Unknown funct3 on LOAD/STORE SHALL be handled as misaligned (err=1, no bus access).
REQ-028 Timeout counter SHALL clear on entering REQ, increment each REQ/WAIT cycle, saturate; reaching TIMEOUT_CYCLES SHALL force DONE with err=1, mem_data=NULL.
REQ-029 Stores SHALL report mem_data=NULL in DONE.
REQ-030 mem_data SHALL hold its last value outside DONE.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, mem_data=NULL, done=0, stall=0, err=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
REQ-032 Reset mid-access SHALL drop bus_req asynchronously; a late bus_rvalid after reset release SHALL be ignored in IDLE.

Structure
REQ-033 opcode_t, instr_t, data_t, NULL, LOAD/STORE opcodes, funct3 encodings (LB..LHU, SB..SW) and lsu_state_t SHALL live in package defines.
REQ-034 Load lane select/extension SHALL be sub-module load_extend (combinational: rdata, funct3, offset -> data_t).

Verification
REQ-035 SW rs2=0xDEADBEEF addr=0x100, gnt+rvalid immediate -> bus_be=1111, bus_addr=0x100, done at cycle N+2, err=0.
REQ-036 Word 0x80F0_7F01 at 0x200; LB addr 0x203 -> mem_data 0xFFFFFF80; LBU 0x203 -> 0x00000080; LH 0x202 -> 0xFFFF80F0.
REQ-037 SB rs2=0x000000AB addr=0x101 -> bus_be=0010, bus_wdata=0xABABABAB, bus_addr=0x100.
REQ-038 LW addr 0x102 -> no bus_req, done next cycle, err=1, mem_data=0.
REQ-039 gnt delayed 3 cycles, rvalid 2 after -> bus_* stable throughout, stall=1 until DONE; bus never answers -> err=1 after 255 cycles.
REQ-040 rst_n low during WAIT -> bus_req=0 and stall=0 immediately; stray rvalid after release -> no done.

Source files
------------

// File: rtl/defines.sv
// Shared types and constants for the load/store unit.
package defines;

  typedef logic [31:0] data_t;
  typedef logic [6:0]  opcode_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    opcode_t    opcode;
  } instr_t;

  localparam data_t   NULL  = 32'h0000_0000;
  localparam opcode_t LOAD  = 7'b0000011;
  localparam opcode_t STORE = 7'b0100011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_t;

  // True when the access must not reach the bus: unknown size or misaligned address.
  function automatic logic access_bad(logic is_store, logic [2:0] funct3, logic [1:0] off);
    logic bad;
    bad = 1'b1;
    if (is_store) begin
      case (funct3)
        SB:      bad = 1'b0;
        SH:      bad = off[0];
        SW:      bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        LB, LBU: bad = 1'b0;
        LH, LHU: bad = off[0];
        LW:      bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte-lane selection and sign/zero extension of a loaded bus word.
module load_extend
  import defines::*;
(
  input  data_t      rdata,
  input  logic [2:0] funct3,
  input  logic [1:0] offset,
  output data_t      result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it according to the load size.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'h000000, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns MEM-stage LOAD/STORE instructions into single word-bus transactions.
module lsu
  import defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  instr_t     instr,
  input  data_t      alu_result,
  input  data_t      rs2_data,
  output data_t      mem_data,
  output logic       done,
  output logic       stall,
  output logic       err,
  output logic       bus_req,
  output logic       bus_we,
  output data_t      bus_addr,
  output data_t      bus_wdata,
  output logic [3:0] bus_be,
  input  logic       bus_gnt,
  input  logic       bus_rvalid,
  input  data_t      bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  data_t             addr_q, wdata_q, mem_data_q;
  logic [3:0]        be_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              we_q, err_q;

  logic       is_store, accept, bad, busy, complete, timeout_hit;
  logic [1:0] off;
  logic [3:0] be_d;
  data_t      wdata_d, ext_data;
  logic       unused_instr;

  assign unused_instr = ^{instr.funct7, instr.rs2, instr.rs1, instr.rd};

  assign off      = alu_result[1:0];
  assign is_store = (instr.opcode == STORE);
  assign accept   = valid_in && (state_q == StIdle) && ((instr.opcode == LOAD) || is_store);
  assign bad      = access_bad(is_store, instr.funct3, off);
  assign busy     = (state_q == StReq) || (state_q == StWait);
  // A same-cycle gnt+rvalid in REQ finishes the access without visiting WAIT.
  assign complete = ((state_q == StReq) && bus_gnt && bus_rvalid) ||
                    ((state_q == StWait) && bus_rvalid);
  // Fires on the last allowed REQ/WAIT cycle; a completion in that cycle still wins.
  assign timeout_hit = busy && !complete && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  load_extend u_load_extend (
    .rdata  (bus_rdata),
    .funct3 (f3_q),
    .offset (off_q),
    .result (ext_data)
  );

  // Store byte enables and lane-replicated write data; loads read the whole word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (is_store) begin
      case (instr.funct3)
        SB: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{rs2_data[7:0]}};
        end
        SH: begin
          be_d    = 4'b0011 << off;
          wdata_d = {2{rs2_data[15:0]}};
        end
        default: wdata_d = rs2_data;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = bad ? StDone : StReq;
      StReq: begin
        if (complete || timeout_hit) state_d = StDone;
        else if (bus_gnt)            state_d = StWait;
      end
      StWait: if (complete || timeout_hit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Access registers, timeout counter and the held writeback result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      mem_data_q <= NULL;
    end else if (accept) begin
      addr_q  <= {alu_result[31:2], 2'b00};
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= instr.funct3;
      off_q   <= off;
      we_q    <= is_store;
      err_q   <= bad;
      cnt_q   <= '0;
      if (bad) mem_data_q <= NULL;
    end else if (busy) begin
      if (complete) begin
        err_q      <= 1'b0;
        mem_data_q <= we_q ? NULL : ext_data;
      end else if (timeout_hit) begin
        err_q      <= 1'b1;
        mem_data_q <= NULL;
      end
      if (cnt_q != CntW'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    bus_req = (state_q == StReq);
    done    = (state_q == StDone);
    err     = (state_q == StDone) && err_q;
    stall   = busy || accept;
  end

  assign mem_data  = mem_data_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses against a reference model.
module tb_lsu;
  import defines::*;

  localparam int unsigned Timeout = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  instr_t     instr = '0;
  data_t      alu_result = '0;
  data_t      rs2_data = '0;
  data_t      mem_data;
  logic       done, stall, err;
  logic       bus_req, bus_we;
  data_t      bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic       bus_gnt = 1'b0;
  logic       bus_rvalid = 1'b0;
  data_t      bus_rdata = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit [31:0]   mem [bit [31:0]];

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .instr      (instr),
    .alu_result (alu_result),
    .rs2_data   (rs2_data),
    .mem_data   (mem_data),
    .done       (done),
    .stall      (stall),
    .err        (err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] mem_word(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One complete access. gnt_dly < 0 means the bus never grants.
  task automatic run_access(input logic [6:0] opc, input logic [2:0] f3, input bit [31:0] addr,
                            input bit [31:0] rs2, input int gnt_dly, input int rv_dly);
    bit        is_mem, is_st, sgn, exp_bad, exp_err, never;
    int        size, need, exp_lat, lat, req_cnt, gnt_k, off;
    bit [31:0] word, val, mask, exp_md, exp_wdata, exp_addr;
    bit [3:0]  exp_be;
    bit        granted, req_bad, field_bad, stall_bad;
    instr_t    ins;

    is_mem   = (opc == LOAD) || (opc == STORE);
    is_st    = (opc == STORE);
    never    = (gnt_dly < 0);
    off      = int'(addr % 4);
    exp_addr = addr - addr % 4;
    word     = mem_word(exp_addr);
    size     = 0;
    sgn      = 1'b0;
    if (is_st) begin
      if (f3 == 3'b000) size = 1;
      if (f3 == 3'b001) size = 2;
      if (f3 == 3'b010) size = 4;
    end else begin
      if (f3 == 3'b000) begin size = 1; sgn = 1'b1; end
      if (f3 == 3'b001) begin size = 2; sgn = 1'b1; end
      if (f3 == 3'b010) size = 4;
      if (f3 == 3'b100) size = 1;
      if (f3 == 3'b101) size = 2;
    end
    exp_bad = (size == 0) || (off % size != 0);

    // Store model: enable 'size' lanes from the offset, each lane carries rs2 byte (lane % size).
    exp_be    = 4'b1111;
    exp_wdata = 32'h0;
    if (is_st && !exp_bad) begin
      exp_be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
    end

    // Load model: shift the addressed bytes down, mask, extend.
    val = 32'h0;
    if (!exp_bad) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
      val  = (word >> (8 * off)) & mask;
      if (sgn && size < 4 && val[8*size-1]) val = val | ~mask;
    end

    need = never ? Timeout + 1 : gnt_dly + rv_dly + 1;
    if (exp_bad) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else if (need > Timeout) begin
      exp_lat = Timeout + 1;
      exp_err = 1'b1;
    end else begin
      exp_lat = need + 1;
      exp_err = 1'b0;
    end
    exp_md = (exp_err || is_st) ? 32'h0 : val;

    // Present the instruction for one cycle.
    @(negedge clk);
    ins        = instr_t'($urandom);
    ins.opcode = opc;
    ins.funct3 = f3;
    instr      = ins;
    alu_result = addr;
    rs2_data   = rs2;
    valid_in   = 1'b1;
    #1;
    check("stall_on_accept", {31'b0, stall}, {31'b0, is_mem});
    @(posedge clk);
    #1;
    valid_in   = 1'b0;
    instr      = instr_t'($urandom);
    alu_result = $urandom;

    if (!is_mem) begin
      req_bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        #1;
        if (done || bus_req || stall) req_bad = 1'b1;
      end
      check("passthrough_quiet", {31'b0, req_bad}, 32'h0);
      return;
    end

    lat       = -1;
    req_cnt   = 0;
    gnt_k     = 0;
    granted   = 1'b0;
    req_bad   = 1'b0;
    field_bad = 1'b0;
    stall_bad = 1'b0;
    for (int k = 1; k <= int'(Timeout) + 20 && lat < 0; k++) begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      #1;
      if (done) begin
        lat = k;
      end else begin
        if (stall !== 1'b1) stall_bad = 1'b1;
        if (bus_req) begin
          if (exp_bad || granted) req_bad = 1'b1;
          if (bus_addr !== exp_addr || bus_be !== exp_be || bus_we !== is_st ||
              (is_st && bus_wdata !== exp_wdata)) field_bad = 1'b1;
          if (!never && req_cnt == gnt_dly) begin
            bus_gnt = 1'b1;
            granted = 1'b1;
            gnt_k   = k;
          end
          req_cnt++;
        end else if (!granted) begin
          req_bad = 1'b1;
        end
        if (granted && k == gnt_k + rv_dly) begin
          bus_rvalid = 1'b1;
          bus_rdata  = word;
        end
      end
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;

    check("latency", 32'(lat), 32'(exp_lat));
    check("err", {31'b0, err}, {31'b0, exp_err});
    check("mem_data", mem_data, exp_md);
    check("bus_req_seen", {31'b0, req_cnt > 0}, {31'b0, !exp_bad});
    check("bus_req_shape", {31'b0, req_bad}, 32'h0);
    check("bus_fields", {31'b0, field_bad}, 32'h0);
    check("stall_busy", {31'b0, stall_bad}, 32'h0);
    if (lat >= 0) begin
      check("stall_in_done", {31'b0, stall}, 32'h0);
      @(negedge clk);
      #1;
      check("done_pulse", {31'b0, done}, 32'h0);
      check("mem_data_hold", mem_data, exp_md);
    end
  endtask

  initial begin
    logic [6:0] opc;
    int         r;

    // Reset state.
    #2;
    check("rst_outputs", {mem_data[15:0], 9'b0, done, stall, err, bus_req, bus_we, bus_be[1:0]},
          32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata | {28'h0, bus_be}, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    mem[32'h200] = 32'h80F0_7F01;

    run_access(STORE, SW, 32'h100, 32'hDEAD_BEEF, 0, 0);
    run_access(LOAD, LB, 32'h203, 32'h0, 0, 0);
    run_access(LOAD, LBU, 32'h203, 32'h0, 0, 0);
    run_access(LOAD, LH, 32'h202, 32'h0, 1, 0);
    run_access(STORE, SB, 32'h101, 32'h0000_00AB, 0, 0);
    run_access(LOAD, LW, 32'h102, 32'h0, 0, 0);
    run_access(LOAD, LW, 32'h200, 32'h0, 3, 2);
    run_access(STORE, SH, 32'h202, 32'h1234_5678, 3, 2);
    run_access(7'b0110011, 3'b000, 32'h200, 32'h0, 0, 0);
    run_access(LOAD, LW, 32'h200, 32'h0, -1, 0);
    run_access(LOAD, LHU, 32'h202, 32'h0, 0, 0);

    // Reset in WAIT: bus_req and stall drop at once, a late rvalid is ignored.
    @(negedge clk);
    instr        = '0;
    instr.opcode = LOAD;
    instr.funct3 = LW;
    alu_result   = 32'h200;
    valid_in     = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    check("wait_state", {30'b0, bus_req, stall}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {28'b0, bus_req, stall, done, err}, 32'h0);
    check("async_rst_data", mem_data | bus_addr | {28'h0, bus_be}, 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    r = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      #1;
      if (done || stall || bus_req) r++;
    end
    check("stray_rvalid_ignored", 32'(r), 32'h0);

    // Randomized accesses.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)     opc = 7'b0010011;
      else if (r < 5) opc = STORE;
      else            opc = LOAD;
      if ($urandom_range(0, 3) == 0) mem[32'h300 + 4 * $urandom_range(0, 7)] = $urandom;
      run_access(opc, 3'($urandom_range(0, 7)), 32'h300 + $urandom_range(0, 31), $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
